// File: rtl/fxp_pkg.sv
// Shared constants and width/range helpers for the signed fixed-point arithmetic blocks.
package fxp_pkg;

    localparam int unsigned FXP_DATA_WIDTH = 16;
    localparam int unsigned FXP_FRAC_WIDTH = 14;

    function automatic int unsigned fxp_prod_width(input int unsigned dw);
        return 2 * dw;
    endfunction

    // One guard bit above the full product so the rounding add cannot overflow.
    function automatic int unsigned fxp_shift_width(input int unsigned dw, input int unsigned fw);
        return 2 * dw - fw + 1;
    endfunction

    function automatic longint fxp_max(input int unsigned w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint fxp_min(input int unsigned w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational rescale of a full-width signed product back to the operand Q-format,
// with optional round-half-up and saturation; overflow flag reported either way.
module fxp_round_sat
    import fxp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FXP_DATA_WIDTH,
    parameter int unsigned FRAC_WIDTH = FXP_FRAC_WIDTH,
    parameter bit          ROUND_EN   = 1'b1,
    parameter bit          SAT_EN     = 1'b1
) (
    input  logic [fxp_prod_width(DATA_WIDTH)-1:0] prod,
    output logic [DATA_WIDTH-1:0]                 res,
    output logic                                  ovf
);

    localparam int unsigned PROD_W  = fxp_prod_width(DATA_WIDTH);
    localparam int unsigned SHIFT_W = fxp_shift_width(DATA_WIDTH, FRAC_WIDTH);

    localparam logic [DATA_WIDTH-1:0] SAT_MAX = DATA_WIDTH'(fxp_max(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = DATA_WIDTH'(fxp_min(DATA_WIDTH));

    logic signed [PROD_W:0]    ext;
    logic signed [PROD_W:0]    rnd;
    logic signed [PROD_W:0]    sum;
    logic signed [SHIFT_W-1:0] shifted;
    logic                      in_range;

    always_comb begin
        rnd = '0;
        if (ROUND_EN) rnd[FRAC_WIDTH-1] = 1'b1;
        ext     = {prod[PROD_W-1], prod};
        sum     = ext + rnd;
        shifted = SHIFT_W'(sum >>> FRAC_WIDTH);
        // In range iff every bit from the result sign bit upward is a sign copy.
        in_range = (&shifted[SHIFT_W-1:DATA_WIDTH-1]) | ~(|shifted[SHIFT_W-1:DATA_WIDTH-1]);
        ovf      = ~in_range;
        res      = shifted[DATA_WIDTH-1:0];
        if (!in_range && SAT_EN) res = shifted[SHIFT_W-1] ? SAT_MIN : SAT_MAX;
    end

endmodule

// File: rtl/fxp_mult_pipe.sv
// Pipelined signed fixed-point multiplier: operand regs, product reg, round/saturate reg,
// then plain delay stages; a valid bit travels alongside the data.
module fxp_mult_pipe
    import fxp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FXP_DATA_WIDTH,
    parameter int unsigned FRAC_WIDTH = FXP_FRAC_WIDTH,
    parameter int unsigned PIPE_DEPTH = 5,
    parameter bit          ROUND_EN   = 1'b1,
    parameter bit          SAT_EN     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] p,
    output logic                  ovf,
    output logic                  busy
);

    localparam int unsigned PROD_W = fxp_prod_width(DATA_WIDTH);
    localparam int unsigned DLY    = PIPE_DEPTH - 3;

    logic signed [DATA_WIDTH-1:0] a_q, b_q;
    logic signed [PROD_W-1:0]     prod_q;
    logic [DATA_WIDTH-1:0]        p3, rs_p;
    logic                         ovf3, rs_ovf;
    logic                         v1, v2, v3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
            p3     <= '0;
            ovf3   <= 1'b0;
            v1     <= 1'b0;
            v2     <= 1'b0;
            v3     <= 1'b0;
        end else if (ce) begin
            a_q    <= a;
            b_q    <= b;
            v1     <= in_valid;
            prod_q <= a_q * b_q;
            v2     <= v1;
            p3     <= rs_p;
            ovf3   <= rs_ovf;
            v3     <= v2;
        end
    end

    fxp_round_sat #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH),
        .ROUND_EN   (ROUND_EN),
        .SAT_EN     (SAT_EN)
    ) u_round_sat (
        .prod (prod_q),
        .res  (rs_p),
        .ovf  (rs_ovf)
    );

    generate
        if (DLY == 0) begin : g_direct
            assign out_valid = v3;
            assign p         = p3;
            assign ovf       = ovf3;
            assign busy      = v1 | v2 | v3;
        end else begin : g_delay
            logic [DLY-1:0]        vd;
            logic [DLY-1:0]        od;
            logic [DATA_WIDTH-1:0] pd [DLY];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    vd <= '0;
                    od <= '0;
                    for (int unsigned i = 0; i < DLY; i++) pd[i] <= '0;
                end else if (ce) begin
                    vd[0] <= v3;
                    od[0] <= ovf3;
                    pd[0] <= p3;
                    for (int unsigned i = 1; i < DLY; i++) begin
                        vd[i] <= vd[i-1];
                        od[i] <= od[i-1];
                        pd[i] <= pd[i-1];
                    end
                end
            end

            assign out_valid = vd[DLY-1];
            assign p         = pd[DLY-1];
            assign ovf       = od[DLY-1];
            assign busy      = v1 | v2 | v3 | (|vd);
        end
    endgenerate

endmodule
